pie_input_conditioner: RTL and testbench
========================================

Name: pie_input_conditioner

Overview:
- Front-end stage directly upstream of the tag digital core's PIE input. Cleans the raw envelope-detector output before it reaches the demodulator.
- Functions:
  - synchronises the raw comparator bit into clk;
  - rejects glitches shorter than FILT_LEN cycles;
  - emits edge strobes;
  - measures each low-pulse width;
  - flags carrier loss.
- The filtered level o_pie drives the core's i_pie.

Parameters:
- SYNC_STAGES, 2, synchroniser flop count (>=2).
- FILT_LEN, 3, consecutive differing samples required to change o_pie (>=1).
- CNT_W, 8, low-width counter width.
- LOSS_CYCLES, 200, low duration that declares carrier loss (1 .. 2^CNT_W-1).

Ports:
- clk  in  1  system clock (single clock domain).
- rst  in  1  synchronous, active-high reset.
- i_pie_raw  in  1  asynchronous raw envelope bit; 1 = carrier present.
- i_enable  in  1  block enable.
- o_pie  out  1  filtered PIE level to core.
- o_fall_pie  out  1  one-cycle strobe on o_pie 1->0.
- o_rise_pie  out  1  one-cycle strobe on o_pie 0->1.
- o_low_width  out  CNT_W  cycles o_pie spent low in the last completed low pulse.
- o_width_valid  out  1  one-cycle strobe; o_low_width updated.
- o_carrier_lost  out  1  level; o_pie low for >= LOSS_CYCLES.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - sync flops = 1, o_pie = 1;
  - fcnt = 0, low_cnt = 0, o_low_width = 0;
  - all strobes = 0, o_carrier_lost = 0, state = HIGH.
- Synchroniser: SYNC_STAGES-flop shift of i_pie_raw. sample = last stage.
- Filter counter fcnt:
  - sample == o_pie: fcnt <= 0.
  - else, if fcnt == FILT_LEN-1: o_pie <= sample, fcnt <= 0.
  - else: fcnt++.
- Filter latency: if i_pie_raw is stable from edge N, o_pie changes at edge N+SYNC_STAGES+FILT_LEN-1 (defaults: N+4).
- Strobes: o_fall_pie / o_rise_pie assert in the same cycle o_pie first shows the new value, for exactly one cycle.
- FSM states:
  - HIGH: on fall, go to LOW and set low_cnt <= 1.
  - LOW:
    - no rise: low_cnt increments, saturating at 2^CNT_W-1.
    - rise: o_low_width <= low_cnt; o_width_valid = 1 for one cycle; go to HIGH.
    - low_cnt == LOSS_CYCLES with no rise that cycle: go to LOST; o_carrier_lost <= 1.
  - LOST:
    - low_cnt keeps saturating.
    - on rise: o_carrier_lost <= 0; go to HIGH; o_rise_pie pulses; o_width_valid stays 0 and o_low_width keeps its old value.
- Width semantics: the reported width equals the number of clk edges o_pie was low (rise edge minus fall edge).
- Rise coinciding with low_cnt == LOSS_CYCLES: the rise wins; the width is reported and LOST is not entered.
- i_enable = 0:
  - next edge: state = HIGH, o_pie = 1, fcnt = 0, low_cnt = 0, strobes = 0, o_carrier_lost = 0;
  - synchroniser keeps sampling;
  - o_low_width is held.
- i_enable rising: filtering resumes from o_pie = 1. A raw low at that moment is treated as a fresh fall after the filter delay.
- rst mid-pulse: all reset values are applied next edge. No width strobe is emitted.

Optional Feature:
- Macro: PIE_GLITCH_STATS_EN.
- Defined:
  - adds output o_glitch_cnt (8 bits);
  - increments, saturating at 255, each cycle where fcnt != 0 and sample == o_pie (a rejected glitch);
  - cleared by rst or i_enable = 0.
- Undefined: port and logic are absent. All other behaviour is identical.

Decomposition:
- Package pie_cond_pkg holds:
  - FSM state enum {ST_HIGH, ST_LOW, ST_LOST};
  - default constants for SYNC_STAGES, FILT_LEN, CNT_W, LOSS_CYCLES;
  - GLITCH_CNT_W = 8.
- One sub-module, pie_sync_filter: synchroniser plus filter counter, producing o_pie and the raw-glitch indication.
- Top level holds the edge strobes, FSM, width counter and stats counter.

Test Plan:
- Reset, then i_enable = 1 with i_pie_raw = 1 -> o_pie = 1, no strobes, o_carrier_lost = 0, o_low_width = 0.
- Raw low from edge 10, held 40 cycles, then high (defaults):
  - o_fall_pie at edge 14;
  - o_rise_pie and o_width_valid at edge 54;
  - o_low_width = 40.
- Raw low glitches of 1 and 2 cycles -> o_pie stays 1, no strobes; with PIE_GLITCH_STATS_EN, o_glitch_cnt = 2 afterwards.
- Raw held low 250 cycles:
  - o_carrier_lost rises 200 cycles after o_fall_pie;
  - it clears on o_rise_pie;
  - o_width_valid stays 0 and o_low_width keeps its prior value.
- i_enable dropped 5 cycles into a low pulse -> next edge o_pie = 1, low_cnt cleared, no o_width_valid; re-enable with raw high -> no strobes.
- rst asserted while in LOST -> next edge o_carrier_lost = 0, o_pie = 1, state HIGH; a following 12-cycle low pulse reports o_low_width = 12.

Source files
------------

// File: rtl/pie_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pie_cond_pkg
//  Description : Shared types and default constants for the PIE input
//                conditioner (state encoding, parameter defaults, glitch
//                statistics counter width and saturating increment helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package pie_cond_pkg;

    // Low-pulse tracking states
    typedef enum logic [1:0] {
        ST_HIGH = 2'd0,
        ST_LOW  = 2'd1,
        ST_LOST = 2'd2
    } pie_state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_LEN    = 3;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_LOSS_CYCLES = 200;
    localparam int GLITCH_CNT_W    = 8;

    // Saturating increment for the glitch statistics counter
    function automatic logic [GLITCH_CNT_W-1:0] glitch_sat_inc(
        input logic [GLITCH_CNT_W-1:0] value
    );
        if (value == {GLITCH_CNT_W{1'b1}}) begin
            return value;
        end
        return value + 1'b1;
    endfunction

endpackage : pie_cond_pkg
`default_nettype wire

// File: rtl/pie_sync_filter.sv
`default_nettype none
// ============================================================================
//  Module      : pie_sync_filter
//  Description : Multi-flop synchroniser for the raw envelope bit followed by
//                a consecutive-sample glitch filter. Reports when the filtered
//                level is about to change (o_update) and, when
//                PIE_GLITCH_STATS_EN is defined, when a short excursion was
//                rejected (o_glitch).
//  Revision    : 1.0 - initial release
// ============================================================================
module pie_sync_filter
    import pie_cond_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_LEN    = DEF_FILT_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pie_raw,
    input  logic i_enable,
    output logic o_pie,
    output logic o_update
`ifdef PIE_GLITCH_STATS_EN
    ,
    output logic o_glitch
`endif
);

    localparam int FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FCNT_W-1:0] c_FILT_LAST = FCNT_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
    logic                   pie_q, pie_d;
    logic                   w_sample;
    logic                   w_update;
    logic                   w_glitch;

    assign w_sample = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain; keeps sampling even while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pie_raw};
        end
    end

    // Filter: o_pie follows the sample only after FILT_LEN differing samples
    always_comb begin
        pie_d    = pie_q;
        fcnt_d   = fcnt_q;
        w_update = 1'b0;
        w_glitch = 1'b0;
        if (!i_enable) begin
            pie_d  = 1'b1;
            fcnt_d = '0;
        end else if (w_sample == pie_q) begin
            // A partially counted excursion that collapsed back is a glitch
            w_glitch = (fcnt_q != '0);
            fcnt_d   = '0;
        end else if (fcnt_q == c_FILT_LAST) begin
            pie_d    = w_sample;
            fcnt_d   = '0;
            w_update = 1'b1;
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end
    end

    // Filter state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pie_q  <= 1'b1;
            fcnt_q <= '0;
        end else begin
            pie_q  <= pie_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign o_pie    = pie_q;
    assign o_update = w_update;
`ifdef PIE_GLITCH_STATS_EN
    assign o_glitch = w_glitch;
`else
    // Glitch indication has no consumer without the statistics feature
    logic w_glitch_unused;
    assign w_glitch_unused = w_glitch;
`endif

endmodule : pie_sync_filter
`default_nettype wire

// File: rtl/pie_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : pie_input_conditioner
//  Description : Cleans the raw envelope-detector bit for the PIE demodulator:
//                synchronise, deglitch, edge strobes, low-pulse width
//                measurement and carrier-loss detection.
//                Optional macro PIE_GLITCH_STATS_EN adds o_glitch_cnt, a
//                saturating count of rejected glitches.
//  Revision    : 1.0 - initial release
// ============================================================================
module pie_input_conditioner
    import pie_cond_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_LEN    = DEF_FILT_LEN,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LOSS_CYCLES = DEF_LOSS_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_pie_raw,
    input  logic             i_enable,
    output logic             o_pie,
    output logic             o_fall_pie,
    output logic             o_rise_pie,
    output logic [CNT_W-1:0] o_low_width,
    output logic             o_width_valid,
    output logic             o_carrier_lost
`ifdef PIE_GLITCH_STATS_EN
    ,
    output logic [GLITCH_CNT_W-1:0] o_glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_LOSS    = CNT_W'(LOSS_CYCLES);

    pie_state_e       state_q, state_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic [CNT_W-1:0] low_width_q, low_width_d;
    logic             fall_q, fall_d;
    logic             rise_q, rise_d;
    logic             wv_q, wv_d;
    logic             lost_q, lost_d;
    logic             w_pie;
    logic             w_update;
    logic             w_fall;
    logic             w_rise;
    logic [CNT_W-1:0] w_low_cnt_inc;

    pie_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_sync_filter (
        .clk       (clk),
        .rst       (rst),
        .i_pie_raw (i_pie_raw),
        .i_enable  (i_enable),
        .o_pie     (w_pie),
        .o_update  (w_update)
`ifdef PIE_GLITCH_STATS_EN
        ,
        .o_glitch  (w_glitch)
`endif
    );

    // The filter flags the edge one cycle ahead, so registering the
    // strobes aligns them with the cycle o_pie shows the new level.
    assign w_fall        = w_update &  w_pie;
    assign w_rise        = w_update & ~w_pie;
    assign w_low_cnt_inc = (low_cnt_q == c_CNT_MAX) ? low_cnt_q : low_cnt_q + 1'b1;

    // Next-state logic for the low-pulse FSM, width counter and strobes
    always_comb begin
        state_d     = state_q;
        low_cnt_d   = low_cnt_q;
        low_width_d = low_width_q;
        fall_d      = w_fall;
        rise_d      = w_rise;
        wv_d        = 1'b0;
        lost_d      = lost_q;
        if (!i_enable) begin
            state_d   = ST_HIGH;
            low_cnt_d = '0;
            fall_d    = 1'b0;
            rise_d    = 1'b0;
            lost_d    = 1'b0;
        end else begin
            case (state_q)
                ST_HIGH: begin
                    if (w_fall) begin
                        state_d   = ST_LOW;
                        low_cnt_d = CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    // A rise on the loss boundary cycle still reports a width
                    if (w_rise) begin
                        low_width_d = low_cnt_q;
                        wv_d        = 1'b1;
                        low_cnt_d   = '0;
                        state_d     = ST_HIGH;
                    end else begin
                        low_cnt_d = w_low_cnt_inc;
                        if (low_cnt_q == c_LOSS) begin
                            state_d = ST_LOST;
                            lost_d  = 1'b1;
                        end
                    end
                end
                ST_LOST: begin
                    if (w_rise) begin
                        lost_d    = 1'b0;
                        low_cnt_d = '0;
                        state_d   = ST_HIGH;
                    end else begin
                        low_cnt_d = w_low_cnt_inc;
                    end
                end
                default: begin
                    state_d   = ST_HIGH;
                    low_cnt_d = '0;
                    lost_d    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HIGH;
            low_cnt_q   <= '0;
            low_width_q <= '0;
            fall_q      <= 1'b0;
            rise_q      <= 1'b0;
            wv_q        <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            low_cnt_q   <= low_cnt_d;
            low_width_q <= low_width_d;
            fall_q      <= fall_d;
            rise_q      <= rise_d;
            wv_q        <= wv_d;
            lost_q      <= lost_d;
        end
    end

`ifdef PIE_GLITCH_STATS_EN
    logic                    w_glitch;
    logic [GLITCH_CNT_W-1:0] glitch_cnt_q;

    // Saturating count of rejected glitches, cleared while disabled
    always_ff @(posedge clk) begin
        if (rst || !i_enable) begin
            glitch_cnt_q <= '0;
        end else if (w_glitch) begin
            glitch_cnt_q <= glitch_sat_inc(glitch_cnt_q);
        end
    end

    assign o_glitch_cnt = glitch_cnt_q;
`endif

    assign o_pie          = w_pie;
    assign o_fall_pie     = fall_q;
    assign o_rise_pie     = rise_q;
    assign o_low_width    = low_width_q;
    assign o_width_valid  = wv_q;
    assign o_carrier_lost = lost_q;

endmodule : pie_input_conditioner
`default_nettype wire

// File: tb/tb_pie_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pie_input_conditioner
//  Description : Directed self-checking bench for pie_input_conditioner with
//                an event scoreboard (strobes and carrier-loss transitions).
//                Honours PIE_GLITCH_STATS_EN for the glitch counter check.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pie_input_conditioner;

    localparam int c_LAT  = 4;    // SYNC_STAGES + FILT_LEN - 1
    localparam int c_LOSS = 200;

    localparam int K_FALL = 0;
    localparam int K_RISE = 1;
    localparam int K_WV   = 2;
    localparam int K_LSET = 3;
    localparam int K_LCLR = 4;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_pie_raw;
    logic       i_enable;
    logic       o_pie;
    logic       o_fall_pie;
    logic       o_rise_pie;
    logic [7:0] o_low_width;
    logic       o_width_valid;
    logic       o_carrier_lost;
`ifdef PIE_GLITCH_STATS_EN
    logic [7:0] o_glitch_cnt;
`endif

    int  n_assert = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  exp_width;
    ev_t exp_q[$];
    logic lost_prev = 1'b0;

    pie_input_conditioner dut (
        .clk            (clk),
        .rst            (rst),
        .i_pie_raw      (i_pie_raw),
        .i_enable       (i_enable),
        .o_pie          (o_pie),
        .o_fall_pie     (o_fall_pie),
        .o_rise_pie     (o_rise_pie),
        .o_low_width    (o_low_width),
        .o_width_valid  (o_width_valid),
        .o_carrier_lost (o_carrier_lost)
`ifdef PIE_GLITCH_STATS_EN
        ,
        .o_glitch_cnt   (o_glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Edge number of the most recent rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int kind, input int c, input int val);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            e.kind = -1;
            e.cyc  = -1;
            e.val  = -1;
        end else begin
            e = exp_q.pop_front();
        end
        n_assert++;
        assert (kind === e.kind && cyc === e.cyc && val === e.val) else begin
            n_fail++;
            $error("FAIL event: observed kind=%0d cyc=%0d val=%0d, expected kind=%0d cyc=%0d val=%0d",
                   kind, cyc, val, e.kind, e.cyc, e.val);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every strobe / loss transition must match the scoreboard
    always @(negedge clk) begin
        if (o_fall_pie === 1'b1)    check_ev(K_FALL, 0);
        if (o_rise_pie === 1'b1)    check_ev(K_RISE, 0);
        if (o_width_valid === 1'b1) check_ev(K_WV, int'(o_low_width));
        if (o_carrier_lost === 1'b1 && lost_prev === 1'b0) check_ev(K_LSET, 0);
        if (o_carrier_lost === 1'b0 && lost_prev === 1'b1) check_ev(K_LCLR, 0);
        lost_prev = o_carrier_lost;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Low pulse of L cycles on the raw input, then a settle gap
    task automatic pulse(input int L);
        int n;
        n = cyc + 1;
        push(K_FALL, n + c_LAT, 0);
        if (L > c_LOSS) push(K_LSET, n + c_LAT + c_LOSS, 0);
        push(K_RISE, n + L + c_LAT, 0);
        if (L > c_LOSS) begin
            push(K_LCLR, n + L + c_LAT, 0);
        end else begin
            push(K_WV, n + L + c_LAT, L);
            exp_width = L;
        end
        i_pie_raw = 1'b0;
        tick(L);
        i_pie_raw = 1'b1;
        tick(12);
        chk("low_width_after_pulse", 32'(o_low_width), 32'(exp_width));
        chk("pie_high_after_pulse", 32'(o_pie), 32'd1);
        chk("lost_after_pulse", 32'(o_carrier_lost), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_width = 0;
        rst       = 1'b1;
        i_enable  = 1'b0;
        i_pie_raw = 1'b1;
        tick(3);
        rst      = 1'b0;
        i_enable = 1'b1;
        tick(3);

        // Reset / idle state
        chk("reset_pie", 32'(o_pie), 32'd1);
        chk("reset_fall", 32'(o_fall_pie), 32'd0);
        chk("reset_rise", 32'(o_rise_pie), 32'd0);
        chk("reset_lost", 32'(o_carrier_lost), 32'd0);
        chk("reset_low_width", 32'(o_low_width), 32'd0);

        // Normal 40-cycle low pulse
        pulse(40);

        // Short glitches must be rejected
        i_pie_raw = 1'b0; tick(1);
        i_pie_raw = 1'b1; tick(6);
        i_pie_raw = 1'b0; tick(2);
        i_pie_raw = 1'b1; tick(6);
        chk("glitch_pie", 32'(o_pie), 32'd1);
        chk("glitch_width_held", 32'(o_low_width), 32'd40);
`ifdef PIE_GLITCH_STATS_EN
        chk("glitch_cnt", 32'(o_glitch_cnt), 32'd2);
`endif

        // Rise exactly on the loss boundary: width wins, no loss
        pulse(200);
        pulse(7);

        // Carrier loss: width not reported, previous width kept
        pulse(250);
        chk("loss_width_kept", 32'(o_low_width), 32'd7);

        // Enable dropped five cycles into a low pulse
        n = cyc + 1;
        push(K_FALL, n + c_LAT, 0);
        i_pie_raw = 1'b0;
        tick(c_LAT + 5);
        i_enable = 1'b0;
        tick(1);
        chk("disable_pie", 32'(o_pie), 32'd1);
        chk("disable_wv", 32'(o_width_valid), 32'd0);
        i_pie_raw = 1'b1;
        tick(4);
        i_enable = 1'b1;
        tick(10);
        chk("reenable_pie", 32'(o_pie), 32'd1);
        chk("disable_width_held", 32'(o_low_width), 32'd7);

        // Reset while in LOST
        n = cyc + 1;
        push(K_FALL, n + c_LAT, 0);
        push(K_LSET, n + c_LAT + c_LOSS, 0);
        i_pie_raw = 1'b0;
        tick(220);
        chk("lost_before_rst", 32'(o_carrier_lost), 32'd1);
        rst       = 1'b1;
        i_pie_raw = 1'b1;
        push(K_LCLR, cyc + 1, 0);
        tick(1);
        chk("rst_lost", 32'(o_carrier_lost), 32'd0);
        chk("rst_pie", 32'(o_pie), 32'd1);
        chk("rst_low_width", 32'(o_low_width), 32'd0);
        rst = 1'b0;
        exp_width = 0;
        tick(5);
        pulse(12);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_pie_input_conditioner
`default_nettype wire
